// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Queues change amounts from the vending controller and pays them
//            out coin by coin to a two-hopper ejector over req/ack. Falls back
//            to 1-unit coins when the 2-unit hopper is empty and latches a
//            fault that reports the unpaid amount.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vend_valid,
   input  logic [2:0] change_amt,
   input  logic       hopper2_empty,
   input  logic       hopper1_empty,
   input  logic       eject_ack,
   input  logic       clear_fault,
   output logic       eject_req,
   output logic [1:0] eject_coin,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [2:0] owed,
   output logic       overflow
);

   localparam int         c_aw      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] c_timeout = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_REQ    = 3'd2,
      S_GAP    = 3'd3,
      S_FAULT  = 3'd4
   } state_t;

   state_t       state_q, state_d;
   logic [2:0]   rem_q, rem_d;
   logic [1:0]   coin_q, coin_d;
   logic [7:0]   cnt_q, cnt_d;
   logic         overflow_q;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [2:0]   fifo_q [DEPTH];
   logic [c_aw:0] wr_ptr_q, rd_ptr_q;

   logic         w_empty;
   logic         w_full;
   logic         w_pop;
   logic         w_push_req;
   logic         w_push;

   assign w_empty    = (wr_ptr_q == rd_ptr_q);
   assign w_full     = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                       (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);
   assign w_pop      = (state_q == S_IDLE) && !w_empty;
   assign w_push_req = vend_valid && (change_amt != 3'd0);
   // A full FIFO still accepts a vend when the head leaves in the same cycle.
   assign w_push     = w_push_req && (!w_full || w_pop);

   assign busy     = (state_q != S_IDLE) || !w_empty;
   assign overflow = overflow_q;

   // FIFO storage; pointers alone define occupancy so no reset is needed here.
   always_ff @(posedge clk) begin
      if (w_push) begin
         fifo_q[wr_ptr_q[c_aw-1:0]] <= change_amt;
      end
   end

   // State, payout registers, FIFO pointers and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rem_q      <= 3'd0;
         coin_q     <= 2'd0;
         cnt_q      <= 8'd0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         coin_q  <= coin_d;
         cnt_q   <= cnt_d;
         if (w_push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (w_push_req && w_full && !w_pop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Payout sequencing: next state, remainder/coin/timeout updates, outputs.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      coin_d     = coin_q;
      cnt_d      = cnt_q;
      eject_req  = 1'b0;
      eject_coin = 2'd0;
      done       = 1'b0;
      fault      = 1'b0;
      owed       = 3'd0;
      case (state_q)
         S_IDLE: begin
            if (!w_empty) begin
               rem_d   = fifo_q[rd_ptr_q[c_aw-1:0]];
               state_d = S_SELECT;
            end
         end
         S_SELECT: begin
            cnt_d = 8'd0;
            if (rem_q == 3'd0) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else if ((rem_q >= 3'd2) && !hopper2_empty) begin
               coin_d  = 2'd2;
               state_d = S_REQ;
            end else if (!hopper1_empty) begin
               coin_d  = 2'd1;
               state_d = S_REQ;
            end else begin
               state_d = S_FAULT;
            end
         end
         S_REQ: begin
            eject_req  = 1'b1;
            eject_coin = coin_q;
            if (eject_ack) begin
               // coin_q is 2 only when rem_q >= 2, so this cannot wrap.
               rem_d   = rem_q - {1'b0, coin_q};
               cnt_d   = 8'd0;
               state_d = S_GAP;
            end else if (cnt_q == c_timeout) begin
               cnt_d   = 8'd0;
               state_d = S_FAULT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_GAP: begin
            state_d = S_SELECT;
         end
         S_FAULT: begin
            fault = 1'b1;
            owed  = rem_q;
            if (clear_fault) begin
               rem_d   = 3'd0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire
